// File: rtl/loop_countdown.sv
// loop_countdown -- counted-loop sequencer.
//
// One start with a count of N produces N index beats, N-1 down to 0, on a
// valid/ready stream. acc counts the accepted beats, and done pulses once for
// a single cycle when the loop completes. A count of zero skips straight to
// the done pulse without producing any beats.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   start      begin an iteration (only looked at in IDLE)
//   count      iteration count N, sampled with start
//   out_ready  downstream takes the current index this cycle
//   out_valid  idx holds a valid index (RUN only)
//   idx        current loop index
//   acc        number of accepted indices so far
//   busy       high in RUN and DONE
//   done       one-cycle end-of-loop pulse
//
// Every output is a flop, so there is no combinational path from any input
// to any output.
module loop_countdown #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] idx,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Without start every register holds, so acc and idx
                    // keep the result of the previous loop.
                    if (start) begin
                        acc  <= '0;
                        busy <= 1'b1;
                        if (count != '0) begin
                            state     <= RUN;
                            idx       <= count - 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            // Empty loop: no beats, just the done pulse.
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    // out_valid is always high in RUN, so out_ready alone
                    // marks an accepted beat. A stall holds everything.
                    if (out_ready) begin
                        acc <= acc + 1'b1;
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // start is ignored here; it is only honoured in the
                    // IDLE cycle that follows.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_countdown.sv
module tb_loop_countdown;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] count;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] idx;
    logic [W-1:0] acc;
    logic         busy;
    logic         done;

    loop_countdown #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .idx       (idx),
        .acc       (acc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] idx;
        logic [W-1:0] acc;
    } beat_t;

    beat_t        exp_beats[$];
    logic [W-1:0] exp_done[$];

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int done_target = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        beat_t        b;
        logic [W-1:0] d;
        logic         prev_accept = 1'b0;
        logic         prev_zero   = 1'b0;
        logic         prev_stall  = 1'b0;
        logic [W-1:0] prev_idx    = '0;
        logic [W-1:0] prev_acc    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", {24'd0, idx}, 32'hFFFF_FFFF);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_idx", {24'd0, idx}, {24'd0, b.idx});
                    check("beat_acc", {24'd0, acc}, {24'd0, b.acc});
                end
            end
            if (rst_n && out_valid)
                check("valid_implies_busy", {31'd0, busy}, 32'd1);
            if (rst_n && done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    check("unexpected_done", {24'd0, acc}, 32'hFFFF_FFFF);
                end else begin
                    d = exp_done.pop_front();
                    check("done_acc", {24'd0, acc}, {24'd0, d});
                end
                check("done_latency", {31'd0, prev_accept | prev_zero}, 32'd1);
                check("done_busy", {31'd0, busy}, 32'd1);
                check("done_no_valid", {31'd0, out_valid}, 32'd0);
            end
            if (rst_n && prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_idx", {24'd0, idx}, {24'd0, prev_idx});
                check("stall_acc", {24'd0, acc}, {24'd0, prev_acc});
            end
            prev_accept = rst_n && out_valid && out_ready;
            prev_zero   = rst_n && start && (count == '0) && !busy;
            prev_stall  = rst_n && out_valid && !out_ready;
            prev_idx    = idx;
            prev_acc    = acc;
        end
    end

    // Drive start for one cycle from an IDLE cycle and queue the expected
    // beats (N-1 .. 0, acc 0 .. N-1) and the final acc at the done pulse.
    task automatic issue(input int n);
        beat_t b;
        start = 1'b1;
        count = W'(n);
        for (int i = 0; i < n; i++) begin
            b.idx = W'(n - 1 - i);
            b.acc = W'(i);
            exp_beats.push_back(b);
        end
        exp_done.push_back(W'(n));
        done_target++;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns #1 after the edge that leaves DONE, i.e. in the following IDLE cycle.
    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (done_seen < done_target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_seen < done_target) begin
            total++;
            bad++;
            $display("FAIL %s timeout actual=%0d required=%0d", name, done_seen, done_target);
            done_seen = done_target;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        count = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_idx",   {24'd0, idx}, 32'd0);
        check("rst_acc",   {24'd0, acc}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);

        // count=3, start in first cycle after reset release
        rst_n = 1'b1;
        issue(3);
        check("t1_run_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done", 20);
        check("t1_acc",  {24'd0, acc}, 32'd3);
        check("t1_idx",  {24'd0, idx}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // count=0: done one cycle later, no beats
        issue(0);
        check("t2_valid", {31'd0, out_valid}, 32'd0);
        wait_done("t2_done", 10);
        check("t2_acc", {24'd0, acc}, 32'd0);

        // count=2 with 4 stall cycles
        out_ready = 1'b0;
        issue(2);
        check("t3_valid0", {31'd0, out_valid}, 32'd1);
        check("t3_idx0",   {24'd0, idx}, 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("t3_valid4", {31'd0, out_valid}, 32'd1);
        check("t3_idx4",   {24'd0, idx}, 32'd1);
        check("t3_acc4",   {24'd0, acc}, 32'd0);
        out_ready = 1'b1;
        wait_done("t3_done", 10);
        check("t3_acc", {24'd0, acc}, 32'd2);

        // count=5, second start mid-RUN ignored
        issue(5);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1;
        count = W'(9);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t4_done", 20);
        check("t4_acc", {24'd0, acc}, 32'd5);
        repeat (3) begin @(posedge clk); #1; end
        check("t4_no_restart", {31'd0, busy}, 32'd0);

        // count=4, reset after 2 accepted beats, then count=1
        issue(4);
        repeat (2) begin @(posedge clk); #1; end
        check("t5_idx_pre", {24'd0, idx}, 32'd1);
        rst_n = 1'b0;
        exp_beats.delete();
        exp_done.delete();
        done_target--;
        @(posedge clk); #1;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_idx",   {24'd0, idx}, 32'd0);
        check("t5_acc",   {24'd0, acc}, 32'd0);
        check("t5_busy",  {31'd0, busy}, 32'd0);
        check("t5_done",  {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        issue(1);
        wait_done("t5_restart", 10);
        check("t5_acc_after", {24'd0, acc}, 32'd1);

        // Back-to-back: restart in the IDLE cycle right after DONE
        issue(1);
        wait_done("t6_first", 10);
        issue(1);
        wait_done("t6_second", 10);
        check("t6_acc", {24'd0, acc}, 32'd1);

        // Maximum count 2^W-1
        issue(255);
        wait_done("t7_done", 400);
        check("t7_acc", {24'd0, acc}, 32'd255);
        check("t7_idx", {24'd0, idx}, 32'd0);

        repeat (3) begin @(posedge clk); #1; end
        check("beats_left", exp_beats.size(), 32'd0);
        check("dones_left", exp_done.size(), 32'd0);
        check("done_count", done_seen, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", done_seen, done_target);
        $fatal(1, "timeout");
    end

endmodule
